// File: rtl/core_sequencer_if.sv
// Bus bundle for core_sequencer: program load, run control, operand/result data.
// Latency: n/a (wires only).
// Backpressure: the result handshake is result_valid_o / result_ready_i; everything else is unthrottled.
//
// Signals (named from the sequencer's point of view, _i = into the sequencer):
//   prog_we_i/prog_addr_i/prog_data_i   program store write port
//   start_i/length_i/loops_i/abort_i    run control
//   input_i/results_i                   core operands in, core results in
//   result_ready_i                      consumer accepts result
//   instruction_o                       broadcast instruction to the core row
//   input_o/result_o/result_valid_o     held operands, captured results, result valid
//   busy_o                              sequencer not idle
interface core_sequencer_if #(
   parameter int ADDR_W     = 7,
   parameter int PROG_DEPTH = 128,
   parameter int NUM_CORES  = 4,
   parameter int DATA_W     = 64
);
   localparam int INSTR_W = ADDR_W + 10;
   localparam int PC_W    = $clog2(PROG_DEPTH);
   localparam int BUS_W   = NUM_CORES * DATA_W;

   logic               prog_we_i;
   logic [PC_W-1:0]    prog_addr_i;
   logic [INSTR_W-1:0] prog_data_i;
   logic               start_i;
   logic [PC_W:0]      length_i;
   logic [7:0]         loops_i;
   logic               abort_i;
   logic [BUS_W-1:0]   input_i;
   logic [BUS_W-1:0]   results_i;
   logic               result_ready_i;
   logic [INSTR_W-1:0] instruction_o;
   logic [BUS_W-1:0]   input_o;
   logic [BUS_W-1:0]   result_o;
   logic               result_valid_o;
   logic               busy_o;

   modport master (
      output prog_we_i, prog_addr_i, prog_data_i, start_i, length_i, loops_i,
             abort_i, input_i, results_i, result_ready_i,
      input  instruction_o, input_o, result_o, result_valid_o, busy_o
   );

   modport slave (
      input  prog_we_i, prog_addr_i, prog_data_i, start_i, length_i, loops_i,
             abort_i, input_i, results_i, result_ready_i,
      output instruction_o, input_o, result_o, result_valid_o, busy_o
   );
endinterface

// File: rtl/core_sequencer.sv
// Program sequencer: plays a loaded program LOOPS times onto a broadcast instruction bus, drains, captures results.
// Latency: start edge to result_valid_o = len*loops + DRAIN_CYCLES + 1 edges.
// Backpressure: result_valid_o held in DONE until result_ready_i; new starts only accepted in IDLE.
//
// Ports: clk_i, rst_ni (async active-low) plus the slave side of core_sequencer_if.
module core_sequencer #(
   parameter int ADDR_W       = 7,
   parameter int PROG_DEPTH   = 128,
   parameter int NUM_CORES    = 4,
   parameter int DATA_W       = 64,
   parameter int DRAIN_CYCLES = 2
) (
   input logic                clk_i,
   input logic                rst_ni,
   core_sequencer_if.slave    bus
);
   localparam int INSTR_W = ADDR_W + 10;
   localparam int PC_W    = $clog2(PROG_DEPTH);
   localparam int BUS_W   = NUM_CORES * DATA_W;
   localparam int DC_W    = $clog2(DRAIN_CYCLES + 1);

   localparam logic [PC_W:0]   DEPTH_L = (PC_W+1)'(PROG_DEPTH);
   localparam logic [PC_W:0]   LEN_ONE = (PC_W+1)'(1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [INSTR_W-1:0] r_prog [PROG_DEPTH];
   logic [PC_W-1:0]    r_pc;
   logic [PC_W:0]      r_len;
   logic [7:0]         r_pass, r_loops;
   logic [DC_W-1:0]    r_dcnt;
   logic [INSTR_W-1:0] r_instr;
   logic [BUS_W-1:0]   r_input, r_result;
   logic               r_valid;

   logic               w_accept, w_pc_last, w_pass_last, w_drain_done;
   logic [PC_W:0]      w_len_sat;

   assign w_pc_last    = ({1'b0, r_pc} == (r_len - LEN_ONE));
   assign w_pass_last  = (r_pass == (r_loops - 8'd1));
   assign w_drain_done = (r_dcnt == DC_LAST);
   assign w_len_sat    = (bus.length_i > DEPTH_L) ? DEPTH_L : bus.length_i;

   // Program store has no reset; writes only land while idle so a run always
   // replays what was loaded before it started.
   always_ff @(posedge clk_i) begin
      if (r_state == S_IDLE && bus.prog_we_i)
         r_prog[bus.prog_addr_i] <= bus.prog_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      if (bus.abort_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:  if (bus.start_i && bus.length_i != '0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_RUN;
                     end
            S_RUN:   if (w_pc_last && w_pass_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done)             w_state_nxt = S_DONE;
            S_DONE:  if (bus.result_ready_i)       w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pc     <= '0;
         r_pass   <= '0;
         r_len    <= '0;
         r_loops  <= '0;
         r_dcnt   <= '0;
         r_instr  <= '0;
         r_input  <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
      end else if (bus.abort_i) begin
         // operands and last result stay visible after an abort
         r_instr <= '0;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_accept) begin
               r_len   <= w_len_sat;
               r_loops <= (bus.loops_i == 8'd0) ? 8'd1 : bus.loops_i;
               r_input <= bus.input_i;
               r_pc    <= '0;
               r_pass  <= '0;
            end
            S_RUN: begin
               r_instr <= r_prog[r_pc];
               if (w_pc_last) begin
                  // wrap straight into the next pass: no bubble between passes
                  r_pc <= '0;
                  if (w_pass_last) r_dcnt <= '0;
                  else             r_pass <= r_pass + 8'd1;
               end else begin
                  r_pc <= r_pc + 1'b1;
               end
            end
            S_DRAIN: begin
               r_instr <= '0;
               // DRAIN_CYCLES zero instructions, capture on the edge after them
               if (w_drain_done) begin
                  r_result <= bus.results_i;
                  r_valid  <= 1'b1;
               end else begin
                  r_dcnt <= r_dcnt + 1'b1;
               end
            end
            S_DONE: if (bus.result_ready_i) r_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.instruction_o  = r_instr;
   assign bus.input_o        = r_input;
   assign bus.result_o       = r_result;
   assign bus.result_valid_o = r_valid;
   assign bus.busy_o         = (r_state != S_IDLE);
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: scoreboard of expected instruction stream and result per run.
// Latency: checks start-to-valid edge count on every run.
// Backpressure: exercises DONE hold with result_ready_i low, then ready+start together.
module tb_core_sequencer;
   localparam int ADDR_W = 7, PROG_DEPTH = 128, NUM_CORES = 4, DATA_W = 64, DRAIN_CYCLES = 2;
   localparam int INSTR_W = ADDR_W + 10;
   localparam int PC_W    = $clog2(PROG_DEPTH);
   localparam int BUS_W   = NUM_CORES * DATA_W;

   logic clk, rst_n;

   core_sequencer_if #(.ADDR_W(ADDR_W), .PROG_DEPTH(PROG_DEPTH), .NUM_CORES(NUM_CORES), .DATA_W(DATA_W)) bus();

   core_sequencer #(.ADDR_W(ADDR_W), .PROG_DEPTH(PROG_DEPTH), .NUM_CORES(NUM_CORES),
                    .DATA_W(DATA_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;
   logic [INSTR_W-1:0] m_prog [PROG_DEPTH];
   logic [INSTR_W-1:0] q_ins [$];
   logic [BUS_W-1:0]   q_res [$];
   logic [BUS_W-1:0]   last_res;

   task automatic chk(input string tag, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BUS_W-1:0] rnd_bus();
      logic [BUS_W-1:0] r;
      for (int i = 0; i < BUS_W/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic wr_prog(input int addr, input logic [INSTR_W-1:0] data, input bit track);
      bus.prog_we_i   = 1'b1;
      bus.prog_addr_i = addr[PC_W-1:0];
      bus.prog_data_i = data;
      tick();
      bus.prog_we_i   = 1'b0;
      if (track) m_prog[addr] = data;
   endtask

   task automatic load_spec_prog();
      wr_prog(0, 17'h00001, 1'b1);
      wr_prog(1, 17'h00202, 1'b1);
      wr_prog(2, 17'h1FFFF, 1'b1);
   endtask

   // Drives a start, fills the scoreboard and returns the expected latency.
   task automatic start_run(input int length, input int loops, output int exp_lat);
      int eff_len, eff_loops;
      logic [BUS_W-1:0] in_v, res_v;
      eff_len   = (length > PROG_DEPTH) ? PROG_DEPTH : length;
      eff_loops = (loops == 0) ? 1 : loops;
      in_v  = rnd_bus();
      res_v = rnd_bus();
      bus.length_i  = length[PC_W:0];
      bus.loops_i   = loops[7:0];
      bus.input_i   = in_v;
      bus.results_i = res_v;
      bus.start_i   = 1'b1;
      q_ins.delete();
      q_res.delete();
      for (int p = 0; p < eff_loops; p++)
         for (int i = 0; i < eff_len; i++) q_ins.push_back(m_prog[i]);
      for (int d = 0; d < DRAIN_CYCLES; d++) q_ins.push_back('0);
      q_res.push_back(res_v);
      exp_lat = eff_len * eff_loops + DRAIN_CYCLES + 1;
      tick();
      bus.start_i = 1'b0;
      bus.input_i = rnd_bus();
      chk("busy_on_start", bus.busy_o, 1);
      chk("input_latched", bus.input_o, in_v);
   endtask

   // Checks every broadcast instruction, then waits (bounded) for the result.
   task automatic play(input int exp_lat);
      int n;
      bit early;
      n = 0;
      early = 1'b0;
      while (q_ins.size() > 0) begin
         tick();
         n++;
         if (bus.result_valid_o) early = 1'b1;
         chk("instr", bus.instruction_o, q_ins.pop_front());
      end
      chk("valid_early", early, 0);
      while (!bus.result_valid_o && n < exp_lat + 20) begin
         tick();
         n++;
      end
      chk("valid_set", bus.result_valid_o, 1);
      last_res = q_res.pop_front();
      chk("result", bus.result_o, last_res);
      chk("latency", n, exp_lat);
   endtask

   task automatic accept();
      bus.result_ready_i = 1'b1;
      tick();
      bus.result_ready_i = 1'b0;
      chk("valid_clear", bus.result_valid_o, 0);
      chk("busy_clear", bus.busy_o, 0);
   endtask

   task automatic full_run(input int length, input int loops);
      int lat;
      start_run(length, loops, lat);
      play(lat);
      accept();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      bus.prog_we_i = 1'b0; bus.prog_addr_i = '0; bus.prog_data_i = '0;
      bus.start_i = 1'b0; bus.length_i = '0; bus.loops_i = '0; bus.abort_i = 1'b0;
      bus.input_i = '0; bus.results_i = '0; bus.result_ready_i = 1'b0;
      for (int i = 0; i < PROG_DEPTH; i++) m_prog[i] = '0;
      #12;
      chk("rst_instr", bus.instruction_o, 0);
      chk("rst_input", bus.input_o, 0);
      chk("rst_result", bus.result_o, 0);
      chk("rst_valid", bus.result_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      rst_n = 1'b1;
      tick();

      // async reset in the middle of a run
      load_spec_prog();
      start_run(3, 1, lat);
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_instr", bus.instruction_o, 0);
      chk("mid_rst_input", bus.input_o, 0);
      chk("mid_rst_result", bus.result_o, 0);
      chk("mid_rst_valid", bus.result_valid_o, 0);
      chk("mid_rst_busy", bus.busy_o, 0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_busy", bus.busy_o, 0);

      // basic run, then loops 0 and loops 2
      full_run(3, 1);
      full_run(3, 0);
      full_run(3, 2);

      // zero length ignored; oversize length saturates to depth
      bus.length_i = '0;
      bus.loops_i  = 8'd1;
      bus.start_i  = 1'b1;
      tick();
      bus.start_i = 1'b0;
      chk("len0_busy", bus.busy_o, 0);
      tick();
      chk("len0_busy2", bus.busy_o, 0);
      for (int i = 0; i < PROG_DEPTH; i++) wr_prog(i, INSTR_W'($urandom()), 1'b1);
      full_run(200, 1);

      // abort at pc 1
      load_spec_prog();
      start_run(3, 1, lat);
      tick();
      chk("abort_pre_instr", bus.instruction_o, m_prog[0]);
      bus.abort_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
      chk("abort_instr", bus.instruction_o, 0);
      chk("abort_busy", bus.busy_o, 0);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.result_valid_o) seen = 1'b1;
         end
         chk("abort_no_valid", seen, 0);
      end
      full_run(3, 1);

      // DONE hold under backpressure, dropped writes, ready+start together
      start_run(3, 1, lat);
      play(lat);
      bus.results_i = rnd_bus();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            wr_prog(0, 17'h0AAAA, 1'b0);
         end else begin
            tick();
         end
         chk("hold_valid", bus.result_valid_o, 1);
         chk("hold_result", bus.result_o, last_res);
      end
      bus.result_ready_i = 1'b1;
      bus.start_i  = 1'b1;
      bus.length_i = 8'd3;
      bus.loops_i  = 8'd1;
      tick();
      bus.result_ready_i = 1'b0;
      bus.start_i = 1'b0;
      chk("rdy_start_valid", bus.result_valid_o, 0);
      chk("rdy_start_busy", bus.busy_o, 0);
      tick();
      chk("rdy_start_busy2", bus.busy_o, 0);
      full_run(3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
